conv1_maxpool: RTL and testbench

Streaming ReLU + 2x2/stride-2 max-pool stage sitting directly downstream of the conv1 calculation stage. It consumes one signed convolution result per valid/ready handshake in raster order. It clamps negatives to zero, keeps a half-width row buffer of horizontal partial maxima, and emits one pooled value per 2x2 block to the next layer. Backpressure from the next layer propagates upstream through `maxpool_ready`.

---
 rtl/conv1_maxpool.sv | 132 +++++++++++++
 tb/tb_conv1_maxpool.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conv1_maxpool.sv
// ReLU + 2x2/stride-2 max-pool over a raster stream of signed conv results.
// Latency: pooled value valid on the edge after the block's bottom-right sample is accepted.
// Backpressure: single output register; maxpool_ready = !valid_out_pool || pool_ready stalls every input.
module conv1_maxpool #(
  parameter int DATA_W = 23,
  parameter int CONV_W = 26,
  parameter int CONV_H = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] conv_out_1,
  input  logic                     valid_out_calc,
  output logic                     maxpool_ready,
  output logic signed [DATA_W-1:0] pool_out,
  output logic                     valid_out_pool,
  input  logic                     pool_ready,
  output logic                     pool_last
);

  localparam int HW = CONV_W / 2;
  localparam int HH = CONV_H / 2;
  localparam int CW = (CONV_W > 1) ? $clog2(CONV_W) : 1;
  localparam int RW = (CONV_H > 1) ? $clog2(CONV_H) : 1;
  localparam int BW = (HW > 1) ? $clog2(HW) : 1;

  // Last counted position, and last position that belongs to a complete 2x2 block.
  localparam logic [CW-1:0] COL_END  = CW'(CONV_W - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(CONV_H - 1);
  localparam logic [CW-1:0] COL_PEND = CW'(2 * HW - 1);
  localparam logic [RW-1:0] ROW_PEND = RW'(2 * HH - 1);

  logic [CW-1:0]              col_q, col_d;
  logic [RW-1:0]              row_q, row_d;
  logic signed [DATA_W-1:0]   h_reg_q, h_reg_d;
  logic signed [DATA_W-1:0]   pool_out_q, pool_out_d;
  logic                       valid_q, valid_d;
  logic                       last_q, last_d;
  logic signed [DATA_W-1:0]   rowbuf_q [HW];
  logic signed [DATA_W-1:0]   rowbuf_d [HW];

  logic                       accept;
  logic signed [DATA_W-1:0]   relu;
  logic signed [DATA_W-1:0]   hmax;
  logic signed [DATA_W-1:0]   vmax;
  logic signed [DATA_W-1:0]   rb_rd;
  logic [CW-1:0]              col_half;
  logic [BW-1:0]              rb_idx;
  logic                       in_pool_row;
  logic                       rb_wr;
  logic                       emit;

  assign maxpool_ready  = !valid_q || pool_ready;
  assign pool_out       = pool_out_q;
  assign valid_out_pool = valid_q;
  assign pool_last      = last_q;

  // Datapath: ReLU, horizontal pair max, vertical max against the row buffer.
  always_comb begin
    accept      = valid_out_calc && maxpool_ready;
    relu        = (conv_out_1 < 0) ? '0 : conv_out_1;
    hmax        = (h_reg_q > relu) ? h_reg_q : relu;
    col_half    = col_q >> 1;
    // Only odd columns use the index; they are always inside the buffer range.
    rb_idx      = col_half[BW-1:0];
    rb_rd       = rowbuf_q[rb_idx];
    vmax        = (rb_rd > hmax) ? rb_rd : hmax;
    // A trailing row of an odd-height frame must not disturb the buffer.
    in_pool_row = (row_q <= ROW_PEND);
    rb_wr       = accept && col_q[0] && !row_q[0] && in_pool_row;
    emit        = accept && col_q[0] && row_q[0];
  end

  // Next-state for counters, horizontal register, row buffer and output register.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    h_reg_d    = h_reg_q;
    pool_out_d = pool_out_q;
    valid_d    = valid_q;
    last_d     = last_q;
    rowbuf_d   = rowbuf_q;

    if (accept) begin
      if (col_q == COL_END) begin
        col_d = '0;
        row_d = (row_q == ROW_END) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        h_reg_d = relu;
      end
    end

    if (rb_wr) begin
      rowbuf_d[rb_idx] = hmax;
    end

    if (emit) begin
      pool_out_d = vmax;
      valid_d    = 1'b1;
      last_d     = (col_q == COL_PEND) && (row_q == ROW_PEND);
    end else if (pool_ready) begin
      valid_d = 1'b0;
    end
  end

  // Control and output state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      h_reg_q    <= '0;
      pool_out_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      h_reg_q    <= h_reg_d;
      pool_out_q <= pool_out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  // Row buffer needs no reset: each entry is written on an even row before any odd-row read.
  always_ff @(posedge clk) begin
    rowbuf_q <= rowbuf_d;
  end

endmodule

// File: tb/tb_conv1_maxpool.sv
module tb_conv1_maxpool;
  localparam int DW  = 23;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic signed [DW-1:0] din   [3];
  logic                 vin   [3];
  logic                 prdy  [3];
  logic                 mrdy  [3];
  logic signed [DW-1:0] pout  [3];
  logic                 vout  [3];
  logic                 plast [3];

  conv1_maxpool #(.DATA_W(DW), .CONV_W(4), .CONV_H(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .conv_out_1(din[0]), .valid_out_calc(vin[0]),
    .maxpool_ready(mrdy[0]), .pool_out(pout[0]), .valid_out_pool(vout[0]),
    .pool_ready(prdy[0]), .pool_last(plast[0]));

  conv1_maxpool #(.DATA_W(DW), .CONV_W(5), .CONV_H(5)) u_p5 (
    .clk(clk), .rst_n(rst_n), .conv_out_1(din[1]), .valid_out_calc(vin[1]),
    .maxpool_ready(mrdy[1]), .pool_out(pout[1]), .valid_out_pool(vout[1]),
    .pool_ready(prdy[1]), .pool_last(plast[1]));

  conv1_maxpool #(.DATA_W(DW), .CONV_W(26), .CONV_H(26)) u_p26 (
    .clk(clk), .rst_n(rst_n), .conv_out_1(din[2]), .valid_out_calc(vin[2]),
    .maxpool_ready(mrdy[2]), .pool_out(pout[2]), .valid_out_pool(vout[2]),
    .pool_ready(prdy[2]), .pool_last(plast[2]));

  typedef struct {
    longint val;
    bit     last;
  } exp_t;

  exp_t   exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     frm [0:1351];
  bit     prev_stall;
  longint prev_val;
  bit     prev_last;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: every complete 2x2 block whose bottom-right sample lies among the first n
  // samples yields max(relu(four pixels)); the last block of the frame carries pool_last.
  task automatic model(input int w, input int h, input int base, input int n);
    for (int by = 0; by < h / 2; by++) begin
      for (int bx = 0; bx < w / 2; bx++) begin
        longint m = 0;
        exp_t   e;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            longint v = frm[base + (2 * by + dy) * w + 2 * bx + dx];
            if (v < 0) v = 0;
            if (v > m) m = v;
          end
        end
        if ((2 * by + 1) * w + 2 * bx + 1 < n) begin
          e.val  = m;
          e.last = (bx == w / 2 - 1) && (by == h / 2 - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Called #1 after the input-driving negedge: check handshake rules and consume outputs.
  task automatic observe(input int k);
    chk("rdy_rule", mrdy[k], (!vout[k] || prdy[k]) ? 1 : 0);
    if (prev_stall) begin
      chk("stall_vld", vout[k], 1);
      chk("stall_dat", pout[k], prev_val);
      chk("stall_last", plast[k], prev_last);
    end
    if (vout[k] && prdy[k]) begin
      if (exp_q.size() == 0) begin
        chk("extra_out", vout[k], 0);
      end else begin
        exp_t e = exp_q.pop_front();
        chk("pool_val", pout[k], e.val);
        chk("pool_last", plast[k], e.last);
      end
    end
    prev_stall = vout[k] && !prdy[k];
    prev_val   = pout[k];
    prev_last  = plast[k];
  endtask

  // Offer samples frm[0..n-1] to instance k; pool_ready is low for sl cycles from cycle st.
  task automatic run(input int k, input int n, input int vpct, input int st, input int sl);
    int i   = 0;
    int cyc = 0;
    bit acc;
    while (i < n && cyc < 20000) begin
      @(negedge clk);
      prdy[k] = !(cyc >= st && cyc < st + sl);
      vin[k]  = ($urandom_range(99) < vpct);
      din[k]  = frm[i][DW-1:0];
      #1;
      observe(k);
      acc = vin[k] && mrdy[k];
      @(posedge clk);
      if (acc) i++;
      cyc++;
    end
    chk("accepts", i, n);
  endtask

  task automatic drain(input int k);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      vin[k]  = 1'b0;
      prdy[k] = 1'b1;
      #1;
      observe(k);
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < 3; k++) begin
      chk("rst_vld", vout[k], 0);
      chk("rst_last", plast[k], 0);
      chk("rst_dat", pout[k], 0);
      chk("rst_rdy", mrdy[k], 1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    prev_stall = 1'b0;
    prev_val   = 0;
    prev_last  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[k]  = '0;
      vin[k]  = 1'b0;
      prdy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // All-negative 4x4: four zeros, last flag on the fourth.
    for (int i = 0; i < 16; i++) frm[i] = -5;
    model(4, 4, 0, 16);
    run(0, 16, 100, BIG, 0);
    drain(0);

    // Ramp 0..15 then, with no bubble, the ramp with -100 at 5,7,13,15.
    for (int i = 0; i < 16; i++) begin
      frm[i]      = i;
      frm[16 + i] = (i == 5 || i == 7 || i == 13 || i == 15) ? -100 : i;
    end
    model(4, 4, 0, 16);
    model(4, 4, 16, 16);
    run(0, 32, 100, BIG, 0);
    drain(0);

    // Width extremes: one block holds the positive max, all else the negative min.
    for (int i = 0; i < 16; i++) frm[i] = -4194304;
    frm[6] = 4194303;
    model(4, 4, 0, 16);
    run(0, 16, 60, BIG, 0);
    drain(0);

    // Odd 5x5: trailing column/row carry 1000 and must be discarded; random frame follows.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        frm[r * 5 + c] = (r == 4 || c == 4) ? 1000 : 9;
    for (int i = 25; i < 50; i++) frm[i] = int'($urandom_range(2000)) - 1000;
    model(5, 5, 0, 25);
    model(5, 5, 25, 25);
    run(1, 50, 80, BIG, 0);
    drain(1);

    // Default 26x26 random frame, random valid, 7-cycle downstream stall in an odd row.
    for (int i = 0; i < 676; i++) frm[i] = int'($urandom_range(8388607)) - 4194304;
    model(26, 26, 0, 676);
    run(2, 676, 70, 45, 7);
    drain(2);

    // Reset after 10 accepts of a ramp frame, then a full ramp frame.
    for (int i = 0; i < 16; i++) frm[i] = i;
    model(4, 4, 0, 10);
    run(0, 10, 100, BIG, 0);
    @(negedge clk);
    vin[0] = 1'b0;
    #1;
    observe(0);
    chk("pre_rst_left", exp_q.size(), 0);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_reset_state();
    end
    @(negedge clk);
    rst_n      = 1'b1;
    prev_stall = 1'b0;
    model(4, 4, 0, 16);
    run(0, 16, 100, BIG, 0);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
